shift_reg_universal: RTL and testbench
======================================

SHIFT_REG_UNIVERSAL -- requirements
Module: shift_reg_universal

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, which is the register width in bits, legal range 2..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enb, input, 1 bit: active-low enable; when it is 1, all state holds.
REQ-005 The block SHALL have port mode, input, 2 bits, with these operations:
- 00 shift;
- 01 rotate;
- 10 parallel load;
- 11 hold.
REQ-006 The block SHALL have port dir, input, 1 bit: 0 = shift/rotate left (toward the MSB), 1 = right (toward the LSB).
REQ-007 The block SHALL have port s_in, input, 1 bit: serial input used in shift mode.
REQ-008 The block SHALL have port d, input, WIDTH bits: parallel load data, typically driven by the upstream per-bit mux stage.
REQ-009 The block SHALL have port q, output, WIDTH bits: registered parallel output.
REQ-010 The block SHALL have port s_out, output, 1 bit: registered serial output, which is the bit most recently shifted or rotated out.
REQ-011 The block SHALL have port cnt, output, ceil(log2(WIDTH+1)) bits: registered count of shift/rotate operations since the last load or reset.
REQ-012 The block SHALL have port done, output, 1 bit: registered, high when cnt == WIDTH.

Function
REQ-013 All outputs SHALL be registered, with a latency of one clk edge from the sampled inputs.
REQ-014 While enb == 1, q, s_out, cnt and done SHALL hold regardless of mode, dir, s_in and d.
REQ-015 Shift left (enb=0, mode=00, dir=0) SHALL perform: q <= {q[WIDTH-2:0], s_in}; s_out <= q[WIDTH-1].
REQ-016 Shift right (enb=0, mode=00, dir=1) SHALL perform: q <= {s_in, q[WIDTH-1:1]}; s_out <= q[0].
REQ-017 Rotate left (enb=0, mode=01, dir=0) SHALL perform: q <= {q[WIDTH-2:0], q[WIDTH-1]}; s_out <= q[WIDTH-1]; s_in is ignored.
REQ-018 Rotate right (enb=0, mode=01, dir=1) SHALL perform: q <= {q[0], q[WIDTH-1:1]}; s_out <= q[0]; s_in is ignored.
REQ-019 Load (enb=0, mode=10) SHALL perform: q <= d; s_out <= 0; cnt <= 0; done <= 0; dir and s_in are ignored.
REQ-020 Hold (enb=0, mode=11) SHALL keep all state unchanged.
REQ-021 Each shift or rotate cycle SHALL increment cnt by 1, saturating at WIDTH; further shifts/rotates at saturation SHALL still move data while cnt stays at WIDTH.
REQ-022 done SHALL be asserted in the same cycle cnt becomes WIDTH, and SHALL stay high until the next load or reset.
REQ-023 A change of dir between consecutive shift cycles SHALL take effect on the next edge, with no idle cycle and no cnt reset.
REQ-024 X or Z on d SHALL matter only in load mode; X or Z on s_in SHALL matter only in shift mode.

Reset
REQ-025 When rst_n == 0, the block SHALL immediately force q=0, s_out=0, cnt=0, done=0, independent of clk.
REQ-026 A reset asserted mid-operation SHALL abort the operation; the first active edge after rst_n rises SHALL execute the mode then presented.
REQ-027 rst_n deassertion SHALL be synchronized externally; the block SHALL NOT require a reset pulse longer than one clk period.

Verification
REQ-028 Scenario: load d=1011, then shift left with s_in=0 for 4 cycles -> q = 0110, 1100, 1000, 0000; s_out = 1, 0, 1, 1; cnt = 1..4; done = 1 on the 4th edge.
REQ-029 Scenario: load 1011, then rotate right for 4 cycles -> q = 1101, 1110, 0111, 1011; s_out = 1, 1, 0, 1; done = 1 with q back at 1011.
REQ-030 Scenario: load 0101, then shift right with s_in=1 for 2 cycles, raise enb for 3 cycles, then shift right once more -> q = 1010, 1101, held at 1101 for 3 cycles, then 1110; cnt = 3.
REQ-031 Scenario: with done=1, apply 2 more shifts, then load d=1111 -> cnt stays 4 during the shifts; after the load, q=1111, cnt=0, done=0, s_out=0.
REQ-032 Scenario: pull rst_n low between clk edges during a shift sequence -> q, s_out, cnt and done go to 0 before the next edge; with mode=11 afterwards, they stay 0.
REQ-033 Scenario: mode=11 with random d, s_in and dir for 10 cycles -> all outputs remain constant.

Source files
------------

// File: rtl/shift_reg_universal.sv
// Universal shift register: shift, rotate, parallel load or hold, with a
// saturating operation counter and a done flag. All outputs are registered.
module shift_reg_universal #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enb,
  input  logic [1:0]                     mode,
  input  logic                           dir,
  input  logic                           s_in,
  input  logic [WIDTH-1:0]               d,
  output logic [WIDTH-1:0]               q,
  output logic                           s_out,
  output logic [$clog2(WIDTH+1)-1:0]     cnt,
  output logic                           done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  typedef enum logic [1:0] {
    OpShift  = 2'b00,
    OpRotate = 2'b01,
    OpLoad   = 2'b10,
    OpHold   = 2'b11
  } op_e;

  if (WIDTH < 2 || WIDTH > 8) begin : gen_width_check
    $error("shift_reg_universal: WIDTH must be in 2..8");
  end

  op_e             op;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             out_bit;
  logic             fill_bit;

  assign op = op_e'(mode);

  // The bit leaving the register is also the rotate fill bit, so shift and
  // rotate differ only in where the vacated position is filled from.
  assign out_bit  = dir ? q_q[0] : q_q[WIDTH-1];
  assign fill_bit = (op == OpShift) ? s_in : out_bit;

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (!enb) begin
      unique case (op)
        OpShift, OpRotate: begin
          q_d    = dir ? {fill_bit, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fill_bit};
          sout_d = out_bit;
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
          end
          done_d = (cnt_d == CntMax);
        end
        OpLoad: begin
          q_d    = d;
          sout_d = 1'b0;
          cnt_d  = '0;
          done_d = 1'b0;
        end
        OpHold: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q     = q_q;
  assign s_out = sout_q;
  assign cnt   = cnt_q;
  assign done  = done_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Scoreboard bench for shift_reg_universal: the driver pushes expected
// results after each edge, a monitor pops and compares on the falling edge.
module tb_shift_reg_universal;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enb;
  logic [1:0]    mode;
  logic          dir;
  logic          s_in;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          s_out;
  logic [CW-1:0] cnt;
  logic          done;

  typedef struct {
    logic [W-1:0] q;
    logic         s_out;
    int           cnt;
    logic         done;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state, kept as plain integers.
  int m_q;
  int m_sout;
  int m_cnt;
  int m_done;

  shift_reg_universal #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enb   (enb),
    .mode  (mode),
    .dir   (dir),
    .s_in  (s_in),
    .d     (d),
    .q     (q),
    .s_out (s_out),
    .cnt   (cnt),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_q = 0; m_sout = 0; m_cnt = 0; m_done = 0;
  endfunction

  function automatic void model_edge(input int e, input int md, input int dr, input int si,
                                     input int dd);
    int mask;
    int leaving;
    int fill;
    mask = (1 << W) - 1;
    if (e != 0) return;
    if (md == 0 || md == 1) begin
      leaving = dr ? (m_q % 2) : (m_q / (1 << (W - 1))) % 2;
      fill    = (md == 0) ? si : leaving;
      if (dr) m_q = (m_q / 2) + fill * (1 << (W - 1));
      else    m_q = ((m_q * 2) + fill) & mask;
      m_sout = leaving;
      m_cnt  = (m_cnt < W) ? m_cnt + 1 : W;
      m_done = (m_cnt == W) ? 1 : 0;
    end else if (md == 2) begin
      m_q = dd & mask; m_sout = 0; m_cnt = 0; m_done = 0;
    end
  endfunction

  function automatic exp_t model_exp(input string tag);
    exp_t x;
    x.q = W'(m_q); x.s_out = m_sout[0]; x.cnt = m_cnt; x.done = m_done[0]; x.tag = tag;
    return x;
  endfunction

  task automatic drive(input logic e, input logic [1:0] md, input logic dr, input logic si,
                       input logic [W-1:0] dd);
    enb = e; mode = md; dir = dr; s_in = si; d = dd;
  endtask

  // Random-mode step: expectation comes from the model.
  task automatic step(input logic e, input logic [1:0] md, input logic dr, input logic si,
                      input logic [W-1:0] dd, input string tag);
    drive(e, md, dr, si, dd);
    @(posedge clk);
    model_edge(int'(e), int'(md), int'(dr), int'(si), int'(dd));
    sb.push_back(model_exp(tag));
    #1;
  endtask

  // Directed step: expectation is a literal worked out by hand.
  task automatic step_chk(input logic e, input logic [1:0] md, input logic dr, input logic si,
                          input logic [W-1:0] dd, input string tag, input logic [W-1:0] eq,
                          input logic es, input int ec, input logic ed);
    exp_t x;
    drive(e, md, dr, si, dd);
    @(posedge clk);
    model_edge(int'(e), int'(md), int'(dr), int'(si), int'(dd));
    x.q = eq; x.s_out = es; x.cnt = ec; x.done = ed; x.tag = tag;
    sb.push_back(x);
    #1;
  endtask

  task automatic check_zero(input string tag);
    tests++;
    if (q !== '0 || s_out !== 1'b0 || cnt !== '0 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s: got q=%b s_out=%b cnt=%0d done=%b, want all zero",
               tag, q, s_out, cnt, done);
    end
  endtask

  // Monitor: one registered result is presented per clock.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (q !== e.q || s_out !== e.s_out || cnt !== CW'(e.cnt) || done !== e.done) begin
          fails++;
          $display("FAIL %s: got q=%b s_out=%b cnt=%0d done=%b, want q=%b s_out=%b cnt=%0d done=%b",
                   e.tag, q, s_out, cnt, done, e.q, e.s_out, e.cnt, e.done);
        end
      end
    end
  end

  task automatic mid_cycle_reset(input logic [1:0] md_after, input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    mode = md_after;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : driver
    model_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'b11, 1'b0, 1'b0, '0);
    #2;
    check_zero("reset");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load, then shift left with s_in=0.
    step_chk(0, 2'b10, 0, 0, 4'b1011, "ld1011",  4'b1011, 0, 0, 0);
    step_chk(0, 2'b00, 0, 0, 4'b0000, "shl1",    4'b0110, 1, 1, 0);
    step_chk(0, 2'b00, 0, 0, 4'b1111, "shl2",    4'b1100, 0, 2, 0);
    step_chk(0, 2'b00, 0, 0, 4'b0000, "shl3",    4'b1000, 1, 3, 0);
    step_chk(0, 2'b00, 0, 0, 4'b0000, "shl4",    4'b0000, 1, 4, 1);
    // Load, then rotate right back to the start.
    step_chk(0, 2'b10, 1, 1, 4'b1011, "ld1011b", 4'b1011, 0, 0, 0);
    step_chk(0, 2'b01, 1, 0, 4'b0000, "ror1",    4'b1101, 1, 1, 0);
    step_chk(0, 2'b01, 1, 1, 4'b0000, "ror2",    4'b1110, 1, 2, 0);
    step_chk(0, 2'b01, 1, 0, 4'b0000, "ror3",    4'b0111, 0, 3, 0);
    step_chk(0, 2'b01, 1, 1, 4'b0000, "ror4",    4'b1011, 1, 4, 1);
    // Shifts at saturation still move data; a load clears everything.
    step_chk(0, 2'b00, 0, 0, 4'b0000, "sat1",    4'b0110, 1, 4, 1);
    step_chk(0, 2'b00, 0, 0, 4'b0000, "sat2",    4'b1100, 0, 4, 1);
    step_chk(0, 2'b10, 0, 1, 4'b1111, "ld1111",  4'b1111, 0, 0, 0);
    // Shift right with enable gaps.
    step_chk(0, 2'b10, 0, 0, 4'b0101, "ld0101",  4'b0101, 0, 0, 0);
    step_chk(0, 2'b00, 1, 1, 4'b0000, "shr1",    4'b1010, 1, 1, 0);
    step_chk(0, 2'b00, 1, 1, 4'b0000, "shr2",    4'b1101, 0, 2, 0);
    step_chk(1, 2'b10, 0, 0, 4'b0000, "enb1",    4'b1101, 0, 2, 0);
    step_chk(1, 2'b00, 0, 1, 4'b1111, "enb2",    4'b1101, 0, 2, 0);
    step_chk(1, 2'b01, 1, 0, 4'b0011, "enb3",    4'b1101, 0, 2, 0);
    step_chk(0, 2'b00, 1, 1, 4'b0000, "shr3",    4'b1110, 1, 3, 0);
    // Direction change without idle cycle or count reset.
    step_chk(0, 2'b00, 0, 1, 4'b0000, "dirchg",  4'b1101, 1, 4, 1);

    // Hold mode with random inputs.
    for (int i = 0; i < 10; i++) begin
      step_chk(0, 2'b11, 1'($urandom), 1'($urandom), W'($urandom), "hold",
               4'b1101, 1, 4, 1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom), 1'($urandom),
           W'($urandom), "rand");
    end

    // Reset in the middle of a shift sequence, then hold.
    step(0, 2'b10, 0, 0, 4'b1001, "pre_ld");
    step(0, 2'b00, 0, 1, 4'b0000, "pre_sh1");
    step(0, 2'b00, 0, 1, 4'b0000, "pre_sh2");
    mid_cycle_reset(2'b11, "midreset");
    for (int i = 0; i < 3; i++) begin
      step_chk(0, 2'b11, 1'($urandom), 1'($urandom), W'($urandom), "post_hold",
               4'b0000, 0, 0, 0);
    end

    // Reset aborts a rotate; first edge afterwards runs the presented shift.
    step(0, 2'b10, 0, 0, 4'b0110, "pre_ld2");
    step(0, 2'b01, 1, 0, 4'b0000, "pre_ror");
    mid_cycle_reset(2'b00, "midreset2");
    step_chk(0, 2'b00, 0, 1, 4'b0000, "post_shl", 4'b0001, 0, 1, 0);
    step_chk(0, 2'b00, 0, 1, 4'b0000, "post_shl2", 4'b0011, 0, 2, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending results, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
